// File: rtl/spi_mem_writer.sv
// spi_mem_writer: SPI-slave (mode 0) command decoder that turns host byte
// streams into pixel-memory writes. Every flop runs on MainClkSrc; the SPI
// pins are oversampled through synchronisers. Decoded data bytes are queued
// in a small write FIFO whose head is offered to the SRAM arbiter with a
// WrReq/WrAck handshake. Overflow and CmdError are sticky until opcode 0x40.
module spi_mem_writer #(
  parameter int ADDR_WIDTH  = 19,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_STEP   = 1
) (
  input  logic                  MainClkSrc,
  input  logic                  ResetN,
  input  logic                  Sclk,
  input  logic                  Mosi,
  input  logic                  CSel,
  output logic                  WrReq,
  output logic [ADDR_WIDTH-1:0] WrAddr,
  output logic [7:0]            WrData,
  input  logic                  WrAck,
  output logic                  Busy,
  output logic                  Overflow,
  output logic                  CmdError
);

  // Number of bytes that make up a full address.
  localparam int ADDR_BYTES = (ADDR_WIDTH + 7) / 8;
  // Largest legal N in a 0x1N set-address opcode.
  localparam logic [3:0] MAX_ADDR_N = 4'(ADDR_BYTES - 1);
  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = ADDR_WIDTH + 8;
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP_V = ADDR_WIDTH'(ADDR_STEP);
  localparam logic [PTR_W:0]        PTR_ONE     = (PTR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ADDR  = 3'd1,
    S_WR1   = 3'd2,
    S_BLEN  = 3'd3,
    S_BURST = 3'd4
  } state_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers and SPI clock edge detection
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] csel_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s;
  logic                   mosi_s;
  logic                   csel_s;
  logic                   sclk_rise_s;

  // Bring the asynchronous SPI pins into the MainClkSrc domain; chip select
  // resets to its inactive (high) level so no bits are captured at start-up.
  always_ff @(posedge MainClkSrc) begin
    if (!ResetN) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      csel_sync_q <= '1;
      sclk_prev_q <= 1'b0;
    end else begin
      sclk_sync_q[0] <= Sclk;
      mosi_sync_q[0] <= Mosi;
      csel_sync_q[0] <= CSel;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sclk_sync_q[i] <= sclk_sync_q[i-1];
        mosi_sync_q[i] <= mosi_sync_q[i-1];
        csel_sync_q[i] <= csel_sync_q[i-1];
      end
      sclk_prev_q <= sclk_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign csel_s      = csel_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;

  // ---------------------------------------------------------------------
  // Bit shifter: assembles MSB-first bytes and pulses byte_valid_q
  // ---------------------------------------------------------------------
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte_q;
  logic       byte_valid_q;

  // Shift Mosi on each synchronised Sclk rise while selected; deselect only
  // rewinds the bit counter so a partial byte is simply forgotten.
  always_ff @(posedge MainClkSrc) begin
    if (!ResetN) begin
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
    end else begin
      byte_valid_q <= 1'b0;
      if (csel_s) begin
        bit_cnt_q <= 3'd0;
      end else if (sclk_rise_s) begin
        shift_q   <= {shift_q[5:0], mosi_s};
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          byte_q       <= {shift_q, mosi_s};
          byte_valid_q <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Command FSM and address register
  // ---------------------------------------------------------------------
  state_t                  state_q;
  logic [7:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    push_q;
  logic [7:0]              push_byte_q;
  logic                    cmd_err_q;
  logic                    clr_ovf_q;

  // Decode opcodes in IDLE and walk the operand bytes. A data byte is turned
  // into a push request for the next cycle; the address advances on that
  // push regardless of whether the FIFO had room.
  always_ff @(posedge MainClkSrc) begin
    if (!ResetN) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      addr_q      <= '0;
      push_q      <= 1'b0;
      push_byte_q <= 8'd0;
      cmd_err_q   <= 1'b0;
      clr_ovf_q   <= 1'b0;
    end else begin
      push_q    <= 1'b0;
      clr_ovf_q <= 1'b0;
      if (push_q) begin
        addr_q <= addr_q + ADDR_STEP_V;
      end
      if (byte_valid_q) begin
        case (state_q)
          S_IDLE: begin
            case (byte_q[7:4])
              4'h0: begin
                // 0x00 is a NOP; any other 0x0N is unknown.
                if (byte_q[3:0] != 4'h0) begin
                  cmd_err_q <= 1'b1;
                end
              end
              4'h1: begin
                if (byte_q[3:0] <= MAX_ADDR_N) begin
                  addr_q  <= '0;
                  cnt_q   <= {4'h0, byte_q[3:0]};
                  state_q <= S_ADDR;
                end else begin
                  cmd_err_q <= 1'b1;
                end
              end
              4'h2: begin
                if (byte_q[3:0] == 4'h0) begin
                  state_q <= S_WR1;
                end else begin
                  cmd_err_q <= 1'b1;
                end
              end
              4'h3: begin
                if (byte_q[3:0] == 4'h0) begin
                  state_q <= S_BLEN;
                end else begin
                  cmd_err_q <= 1'b1;
                end
              end
              4'h4: begin
                if (byte_q[3:0] == 4'h0) begin
                  cmd_err_q <= 1'b0;
                  clr_ovf_q <= 1'b1;
                end else begin
                  cmd_err_q <= 1'b1;
                end
              end
              default: begin
                cmd_err_q <= 1'b1;
              end
            endcase
          end
          S_ADDR: begin
            // Big-endian accumulate; the cast keeps the low ADDR_WIDTH bits.
            addr_q <= ADDR_WIDTH'({addr_q, byte_q});
            if (cnt_q == 8'd0) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          S_WR1: begin
            push_q      <= 1'b1;
            push_byte_q <= byte_q;
            state_q     <= S_IDLE;
          end
          S_BLEN: begin
            cnt_q   <= byte_q;
            state_q <= S_BURST;
          end
          S_BURST: begin
            push_q      <= 1'b1;
            push_byte_q <= byte_q;
            if (cnt_q == 8'd0) begin
              state_q <= S_IDLE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          default: begin
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------
  // Write FIFO with registered head presentation
  // ---------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W:0]     wr_ptr_q;
  logic [PTR_W:0]     rd_ptr_q;
  logic [PTR_W:0]     wr_ptr_d;
  logic [PTR_W:0]     rd_ptr_d;
  logic               wr_req_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [7:0]         wr_data_q;
  logic               busy_q;
  logic               ovf_q;
  logic               full_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               drop_s;
  logic               empty_d;
  logic [ENTRY_W-1:0] push_entry_s;
  logic [ENTRY_W-1:0] head_d;

  assign push_entry_s = {addr_q, push_byte_q};

  // Next-state pointers and the entry that will be at the head next cycle;
  // a push into an otherwise-empty FIFO is forwarded straight to the head.
  always_comb begin
    pop_s     = wr_req_q & WrAck;
    full_s    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    push_ok_s = push_q & (~full_s | pop_s);
    drop_s    = push_q & full_s & ~pop_s;
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    empty_d = (rd_ptr_d == wr_ptr_d);
    if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
      head_d = push_entry_s;
    end else begin
      head_d = mem_q[rd_ptr_d[PTR_W-1:0]];
    end
  end

  // FIFO storage; contents are only meaningful between the pointers.
  always_ff @(posedge MainClkSrc) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[PTR_W-1:0]] <= push_entry_s;
    end
  end

  // Pointers, registered handshake outputs, Busy and the sticky overflow.
  always_ff @(posedge MainClkSrc) begin
    if (!ResetN) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      wr_req_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_req_q <= ~empty_d;
      if (!empty_d) begin
        wr_addr_q <= head_d[ENTRY_W-1:8];
        wr_data_q <= head_d[7:0];
      end
      busy_q <= (state_q != S_IDLE) | push_q | ~empty_d;
      if (drop_s) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf_q) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign WrReq    = wr_req_q;
  assign WrAddr   = wr_addr_q;
  assign WrData   = wr_data_q;
  assign Busy     = busy_q;
  assign Overflow = ovf_q;
  assign CmdError = cmd_err_q;

endmodule
